// File: rtl/cu_vertex_cache_assoc_module.sv
// N-way set-associative vertex-data cache with round-robin replacement, fill de-dup and flush.
// Optional hit/miss statistics counters built when VERTEX_CACHE_STATS_EN is defined.
module cu_vertex_cache_assoc_module #(
    parameter int unsigned VERTEX_CACHE_ENTRIES_NUM = 16,
    parameter int unsigned VERTEX_CACHE_WAYS        = 2,
    parameter int unsigned VERTEX_ID_BITS           = 32,
    parameter int unsigned VERTEX_DATA_BITS         = 64
) (
    input  logic                        clock,
    input  logic                        rstn_in,
    input  logic                        enabled_in,
    input  logic                        flush_in,
    input  logic                        fill_valid_in,
    input  logic [VERTEX_ID_BITS-1:0]   fill_id_in,
    input  logic [VERTEX_DATA_BITS-1:0] fill_data_in,
    input  logic                        lookup_valid_in,
    input  logic [VERTEX_ID_BITS-1:0]   lookup_id_in,
    output logic                        hit_valid_out,
    output logic [VERTEX_ID_BITS-1:0]   hit_id_out,
    output logic [VERTEX_DATA_BITS-1:0] hit_data_out,
    output logic                        miss_valid_out,
    output logic [VERTEX_ID_BITS-1:0]   miss_id_out,
    output logic                        flush_busy_out,
    output logic [31:0]                 hit_count_out,
    output logic [31:0]                 miss_count_out
);

    localparam int unsigned SETS       = VERTEX_CACHE_ENTRIES_NUM / VERTEX_CACHE_WAYS;
    localparam int unsigned INDEX_BITS = $clog2(SETS);
    localparam int unsigned TAG_BITS   = VERTEX_ID_BITS - INDEX_BITS;
    localparam int unsigned WAY_BITS   = (VERTEX_CACHE_WAYS > 1) ? $clog2(VERTEX_CACHE_WAYS) : 1;
    localparam int unsigned ID_W       = VERTEX_ID_BITS;
    localparam int unsigned DATA_W     = VERTEX_DATA_BITS;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    // Internal reset: asserts immediately with rstn_in, releases one clock later
    logic rst_sync_q;
    always_ff @(posedge clock or negedge rstn_in) begin
        if (!rstn_in) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    logic                  enabled_q, enabled_d;
    logic                  lk_valid_q, lk_valid_d;
    logic [ID_W-1:0]       lk_id_q, lk_id_d;
    logic                  fl_valid_q, fl_valid_d;
    logic [ID_W-1:0]       fl_id_q, fl_id_d;
    logic [DATA_W-1:0]     fl_data_q, fl_data_d;

    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_hit_q, s1_hit_d;
    logic [ID_W-1:0]       s1_id_q, s1_id_d;
    logic [DATA_W-1:0]     s1_data_q, s1_data_d;

    logic                  hit_valid_q, hit_valid_d;
    logic [ID_W-1:0]       hit_id_q, hit_id_d;
    logic [DATA_W-1:0]     hit_data_q, hit_data_d;
    logic                  miss_valid_q, miss_valid_d;
    logic [ID_W-1:0]       miss_id_q, miss_id_d;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] flush_cnt_q, flush_cnt_d;
    logic                  flush_busy_q, flush_busy_d;
    logic                  flush_start_c;

    logic                  valid_q [SETS][VERTEX_CACHE_WAYS];
    logic                  valid_d [SETS][VERTEX_CACHE_WAYS];
    logic [TAG_BITS-1:0]   tag_q   [SETS][VERTEX_CACHE_WAYS];
    logic [TAG_BITS-1:0]   tag_d   [SETS][VERTEX_CACHE_WAYS];
    logic [DATA_W-1:0]     data_q  [SETS][VERTEX_CACHE_WAYS];
    logic [DATA_W-1:0]     data_d  [SETS][VERTEX_CACHE_WAYS];
    logic [WAY_BITS-1:0]   rr_q    [SETS];
    logic [WAY_BITS-1:0]   rr_d    [SETS];

    logic [INDEX_BITS-1:0] lk_set_c;
    logic [TAG_BITS-1:0]   lk_tag_c;
    logic                  lk_hit_c;
    logic [DATA_W-1:0]     lk_data_c;

    logic [INDEX_BITS-1:0] fl_set_c;
    logic [TAG_BITS-1:0]   fl_tag_c;
    logic                  fl_match_c;
    logic [WAY_BITS-1:0]   fl_match_way_c;
    logic                  fl_inv_c;
    logic [WAY_BITS-1:0]   fl_inv_way_c;
    logic [WAY_BITS-1:0]   fl_way_c;

    // Stage 0: input capture, gated by the registered enable
    always_comb begin
        enabled_d  = enabled_in;
        lk_valid_d = lookup_valid_in & enabled_q;
        lk_id_d    = lk_valid_d ? lookup_id_in : lk_id_q;
        fl_valid_d = fill_valid_in & enabled_q;
        fl_id_d    = fl_valid_d ? fill_id_in : fl_id_q;
        fl_data_d  = fl_valid_d ? fill_data_in : fl_data_q;
    end

    // Stage 1: parallel tag compare against pre-fill contents; lowest matching way wins
    always_comb begin
        lk_set_c  = lk_id_q[INDEX_BITS-1:0];
        lk_tag_c  = lk_id_q[ID_W-1:INDEX_BITS];
        lk_hit_c  = 1'b0;
        lk_data_c = '0;
        for (int w = int'(VERTEX_CACHE_WAYS) - 1; w >= 0; w--) begin
            if (valid_q[lk_set_c][w] && (tag_q[lk_set_c][w] == lk_tag_c)) begin
                lk_hit_c  = 1'b1;
                lk_data_c = data_q[lk_set_c][w];
            end
        end
        if (state_q == ST_FLUSH) lk_hit_c = 1'b0;
        s1_valid_d = lk_valid_q;
        s1_hit_d   = lk_hit_c;
        s1_id_d    = lk_valid_q ? lk_id_q : s1_id_q;
        s1_data_d  = lk_valid_q ? lk_data_c : s1_data_q;
    end

    // Result stage: exactly one of hit/miss pulses per completed lookup
    always_comb begin
        hit_valid_d  = s1_valid_q & s1_hit_q;
        miss_valid_d = s1_valid_q & ~s1_hit_q;
        hit_id_d     = hit_valid_d ? s1_id_q : hit_id_q;
        hit_data_d   = hit_valid_d ? s1_data_q : hit_data_q;
        miss_id_d    = miss_valid_d ? s1_id_q : miss_id_q;
    end

    // Fill way choice: existing tag, else lowest invalid way, else round-robin victim
    always_comb begin
        fl_set_c       = fl_id_q[INDEX_BITS-1:0];
        fl_tag_c       = fl_id_q[ID_W-1:INDEX_BITS];
        fl_match_c     = 1'b0;
        fl_match_way_c = '0;
        fl_inv_c       = 1'b0;
        fl_inv_way_c   = '0;
        for (int w = int'(VERTEX_CACHE_WAYS) - 1; w >= 0; w--) begin
            if (valid_q[fl_set_c][w] && (tag_q[fl_set_c][w] == fl_tag_c)) begin
                fl_match_c     = 1'b1;
                fl_match_way_c = WAY_BITS'(w);
            end
            if (!valid_q[fl_set_c][w]) begin
                fl_inv_c     = 1'b1;
                fl_inv_way_c = WAY_BITS'(w);
            end
        end
        if (fl_match_c)    fl_way_c = fl_match_way_c;
        else if (fl_inv_c) fl_way_c = fl_inv_way_c;
        else               fl_way_c = rr_q[fl_set_c];
    end

    // Array update: fills only while idle; flush clears one set per cycle
    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        data_d  = data_q;
        rr_d    = rr_q;
        if (fl_valid_q && (state_q == ST_IDLE)) begin
            valid_d[fl_set_c][fl_way_c] = 1'b1;
            tag_d[fl_set_c][fl_way_c]   = fl_tag_c;
            data_d[fl_set_c][fl_way_c]  = fl_data_q;
            if (!fl_match_c && !fl_inv_c) begin
                rr_d[fl_set_c] = (rr_q[fl_set_c] == WAY_BITS'(VERTEX_CACHE_WAYS - 1))
                               ? '0 : rr_q[fl_set_c] + WAY_BITS'(1);
            end
        end
        if (state_q == ST_FLUSH) begin
            for (int w = 0; w < int'(VERTEX_CACHE_WAYS); w++) begin
                valid_d[flush_cnt_q][w] = 1'b0;
            end
        end
    end

    // Flush sequencer next-state
    always_comb begin
        state_d       = state_q;
        flush_cnt_d   = flush_cnt_q;
        flush_start_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_in) begin
                    flush_start_c = 1'b1;
                    state_d       = ST_FLUSH;
                    flush_cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_q == INDEX_BITS'(SETS - 1)) state_d = ST_IDLE;
                else flush_cnt_d = flush_cnt_q + INDEX_BITS'(1);
            end
            default: state_d = ST_IDLE;
        endcase
        flush_busy_d = (state_d == ST_FLUSH);
    end

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            enabled_q    <= 1'b0;
            lk_valid_q   <= 1'b0;
            lk_id_q      <= '0;
            fl_valid_q   <= 1'b0;
            fl_id_q      <= '0;
            fl_data_q    <= '0;
            s1_valid_q   <= 1'b0;
            s1_hit_q     <= 1'b0;
            s1_id_q      <= '0;
            s1_data_q    <= '0;
            hit_valid_q  <= 1'b0;
            hit_id_q     <= '0;
            hit_data_q   <= '0;
            miss_valid_q <= 1'b0;
            miss_id_q    <= '0;
            state_q      <= ST_IDLE;
            flush_cnt_q  <= '0;
            flush_busy_q <= 1'b0;
            for (int s = 0; s < int'(SETS); s++) begin
                rr_q[s] <= '0;
                for (int w = 0; w < int'(VERTEX_CACHE_WAYS); w++) begin
                    valid_q[s][w] <= 1'b0;
                    tag_q[s][w]   <= '0;
                    data_q[s][w]  <= '0;
                end
            end
        end else begin
            enabled_q    <= enabled_d;
            lk_valid_q   <= lk_valid_d;
            lk_id_q      <= lk_id_d;
            fl_valid_q   <= fl_valid_d;
            fl_id_q      <= fl_id_d;
            fl_data_q    <= fl_data_d;
            s1_valid_q   <= s1_valid_d;
            s1_hit_q     <= s1_hit_d;
            s1_id_q      <= s1_id_d;
            s1_data_q    <= s1_data_d;
            hit_valid_q  <= hit_valid_d;
            hit_id_q     <= hit_id_d;
            hit_data_q   <= hit_data_d;
            miss_valid_q <= miss_valid_d;
            miss_id_q    <= miss_id_d;
            state_q      <= state_d;
            flush_cnt_q  <= flush_cnt_d;
            flush_busy_q <= flush_busy_d;
            rr_q         <= rr_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
        end
    end

    assign hit_valid_out  = hit_valid_q;
    assign hit_id_out     = hit_id_q;
    assign hit_data_out   = hit_data_q;
    assign miss_valid_out = miss_valid_q;
    assign miss_id_out    = miss_id_q;
    assign flush_busy_out = flush_busy_q;

`ifdef VERTEX_CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Saturating statistics, counted from the registered result pulses
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (flush_start_c) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else begin
            if (hit_valid_q && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_d  = hit_cnt_q + 32'(1);
            if (miss_valid_q && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_d = miss_cnt_q + 32'(1);
        end
    end

    always_ff @(posedge clock or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count_out  = hit_cnt_q;
    assign miss_count_out = miss_cnt_q;
`else
    assign hit_count_out  = '0;
    assign miss_count_out = '0;
`endif

endmodule

// File: tb/tb_cu_vertex_cache_assoc_module.sv
// Scoreboard bench for cu_vertex_cache_assoc_module (16 entries, 2 ways, 8 sets).
module tb_cu_vertex_cache_assoc_module;

    logic        clock = 1'b0;
    logic        rstn_in;
    logic        enabled_in;
    logic        flush_in;
    logic        fill_valid_in;
    logic [31:0] fill_id_in;
    logic [63:0] fill_data_in;
    logic        lookup_valid_in;
    logic [31:0] lookup_id_in;
    logic        hit_valid_out;
    logic [31:0] hit_id_out;
    logic [63:0] hit_data_out;
    logic        miss_valid_out;
    logic [31:0] miss_id_out;
    logic        flush_busy_out;
    logic [31:0] hit_count_out;
    logic [31:0] miss_count_out;

    cu_vertex_cache_assoc_module dut (
        .clock          (clock),
        .rstn_in        (rstn_in),
        .enabled_in     (enabled_in),
        .flush_in       (flush_in),
        .fill_valid_in  (fill_valid_in),
        .fill_id_in     (fill_id_in),
        .fill_data_in   (fill_data_in),
        .lookup_valid_in(lookup_valid_in),
        .lookup_id_in   (lookup_id_in),
        .hit_valid_out  (hit_valid_out),
        .hit_id_out     (hit_id_out),
        .hit_data_out   (hit_data_out),
        .miss_valid_out (miss_valid_out),
        .miss_id_out    (miss_id_out),
        .flush_busy_out (flush_busy_out),
        .hit_count_out  (hit_count_out),
        .miss_count_out (miss_count_out)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int busy_cnt;
`ifdef VERTEX_CACHE_STATS_EN
    bit stats_en = 1'b1;
`else
    bit stats_en = 1'b0;
`endif

    typedef struct {
        logic        hit;
        logic [31:0] id;
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    // Result expected three negedges after the lookup is driven (sampled edge + 2)
    function automatic void push_exp(input logic hit, input logic [31:0] id, input logic [63:0] data);
        exp_t e;
        e.hit  = hit;
        e.id   = id;
        e.data = data;
        e.cyc  = cyc + 3;
        sb.push_back(e);
        if (hit) exp_hits++;
        else     exp_misses++;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop and compare whenever the DUT presents a result
    always @(negedge clock) begin : monitor
        exp_t e;
        bit   bad;
        if (hit_valid_out || miss_valid_out) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: hit=%0b miss=%0b hit_id=%0h miss_id=%0h cyc=%0d",
                         hit_valid_out, miss_valid_out, hit_id_out, miss_id_out, cyc);
            end else begin
                e   = sb.pop_front();
                bad = (hit_valid_out !== e.hit) || (miss_valid_out !== !e.hit) || (cyc != e.cyc);
                if (e.hit) bad = bad || (hit_id_out !== e.id) || (hit_data_out !== e.data);
                else       bad = bad || (miss_id_out !== e.id);
                if (bad) begin
                    errors++;
                    $display("FAIL lookup_%0h: actual hit=%0b miss=%0b hit_id=%0h data=%0h miss_id=%0h cyc=%0d required hit=%0b id=%0h data=%0h cyc=%0d",
                             e.id, hit_valid_out, miss_valid_out, hit_id_out, hit_data_out,
                             miss_id_out, cyc, e.hit, e.id, e.data, e.cyc);
                end
            end
        end
    end

    task automatic drive(input bit f, input logic [31:0] fid, input logic [63:0] fd,
                         input bit l, input logic [31:0] lid, input bit eh, input logic [63:0] ed);
        @(negedge clock);
        fill_valid_in   = f;
        fill_id_in      = fid;
        fill_data_in    = fd;
        lookup_valid_in = l;
        lookup_id_in    = lid;
        if (l) push_exp(eh, lid, ed);
    endtask

    task automatic fill(input logic [31:0] id, input logic [63:0] d);
        drive(1'b1, id, d, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic look(input logic [31:0] id, input bit h, input logic [63:0] d);
        drive(1'b0, '0, '0, 1'b1, id, h, d);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic chk_stats(input string tag);
        chk({tag, "_hit_count"},  64'(hit_count_out),  stats_en ? 64'(exp_hits)   : 64'd0);
        chk({tag, "_miss_count"}, 64'(miss_count_out), stats_en ? 64'(exp_misses) : 64'd0);
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        rstn_in = 1'b0; enabled_in = 1'b0; flush_in = 1'b0;
        fill_valid_in = 1'b0; fill_id_in = '0; fill_data_in = '0;
        lookup_valid_in = 1'b0; lookup_id_in = '0;
        repeat (3) @(negedge clock);
        chk("rst_hit_valid",  64'(hit_valid_out),  64'd0);
        chk("rst_miss_valid", 64'(miss_valid_out), 64'd0);
        chk("rst_hit_id",     64'(hit_id_out),     64'd0);
        chk("rst_hit_data",   hit_data_out,        64'd0);
        chk("rst_miss_id",    64'(miss_id_out),    64'd0);
        chk("rst_flush_busy", 64'(flush_busy_out), 64'd0);
        chk_stats("rst");

        @(negedge clock);
        rstn_in = 1'b1; enabled_in = 1'b1;
        idle(2);

        // Empty cache miss, then fill and hit
        look(32'h10, 1'b0, '0);
        fill(32'h10, 64'hABCD);
        idle(1);
        look(32'h10, 1'b1, 64'hABCD);

        // Three ids in set 1: third fill evicts way 0 via round robin
        fill(32'h01, 64'h100);
        fill(32'h09, 64'h900);
        fill(32'h11, 64'h1100);
        look(32'h01, 1'b0, '0);
        look(32'h09, 1'b1, 64'h900);
        look(32'h11, 1'b1, 64'h1100);

        // Refill of a resident id overwrites in place; next eviction takes way 1
        fill(32'h09, 64'd1);
        fill(32'h09, 64'd2);
        look(32'h09, 1'b1, 64'd2);
        look(32'h11, 1'b1, 64'h1100);
        fill(32'h19, 64'h1900);
        look(32'h19, 1'b1, 64'h1900);
        look(32'h09, 1'b0, '0);
        look(32'h11, 1'b1, 64'h1100);

        // Same-edge fill and lookup sees old contents; next cycle sees the fill
        drive(1'b1, 32'h20, 64'h2020, 1'b1, 32'h20, 1'b0, '0);
        look(32'h20, 1'b1, 64'h2020);

        // Disable with a lookup in flight; inputs while disabled are dropped
        look(32'h10, 1'b1, 64'hABCD);
        idle(1);
        enabled_in = 1'b0;
        @(negedge clock);
        fill_valid_in = 1'b1; fill_id_in = 32'h30; fill_data_in = 64'h3030;
        lookup_valid_in = 1'b1; lookup_id_in = 32'h30;
        idle(1);
        enabled_in = 1'b1;
        look(32'h30, 1'b0, '0);
        idle(5);
        chk_stats("pre_flush");

        // Flush: 8 busy cycles, lookups miss, fills dropped, re-flush ignored
        @(negedge clock);
        flush_in = 1'b1;
        exp_hits = 0; exp_misses = 0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            flush_in = (i == 4);
            fill_valid_in = 1'b0; lookup_valid_in = 1'b0;
            if (i == 1) begin
                fill_valid_in = 1'b1; fill_id_in = 32'h40; fill_data_in = 64'h4040;
                lookup_valid_in = 1'b1; lookup_id_in = 32'h10;
                push_exp(1'b0, 32'h10, '0);
            end
            if (flush_busy_out) busy_cnt++;
        end
        chk("flush_busy_cycles", 64'(busy_cnt), 64'd8);
        idle(3);
        chk_stats("post_flush");
        look(32'h10, 1'b0, '0);
        look(32'h11, 1'b0, '0);
        look(32'h19, 1'b0, '0);
        look(32'h20, 1'b0, '0);
        look(32'h40, 1'b0, '0);
        fill(32'h40, 64'h4444);
        look(32'h40, 1'b1, 64'h4444);

        // Asynchronous reset in the middle of a flush empties the cache
        fill(32'h50, 64'h5050);
        idle(3);
        @(negedge clock);
        flush_in = 1'b1;
        @(negedge clock);
        flush_in = 1'b0;
        idle(1);
        #2 rstn_in = 1'b0;
        exp_hits = 0; exp_misses = 0;
        #1;
        chk("async_rst_flush_busy", 64'(flush_busy_out), 64'd0);
        idle(2);
        rstn_in = 1'b1;
        idle(2);
        look(32'h50, 1'b0, '0);
        look(32'h40, 1'b0, '0);
        idle(6);
        chk_stats("final");
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
